// File: rtl/pwm_led_driver.sv
// pwm_led_driver
//   One LED channel PWM generator. A prescaler derives a tick from clk, and
//   the tick advances a period counter over 0..PERIOD-1. The duty word is
//   latched only when the period wraps, so a ramp that changes mid-period
//   cannot glitch a pulse width. The compare stage and the output are
//   registered. Polarity is selectable for active-low LED pins.
//
// Ports
//   clk          system clock
//   rst          synchronous active-high reset (priority over en)
//   en           channel enable; low holds the counters at 0 and the LED off
//   duty_in      requested on-time in ticks per period, held by the producer
//   pwm_out      LED drive, inverted when ACTIVE_LOW = 1
//   period_start one-cycle pulse on the cycle a new period begins
//   duty_active  duty value currently in effect
module pwm_led_driver #(
    parameter int WIDTH      = 10,
    parameter int PERIOD     = 1023,  // 2 .. 2**WIDTH-1
    parameter int PRESCALE   = 1,     // >= 1
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] duty_in,
    output logic             pwm_out,
    output logic             period_start,
    output logic [WIDTH-1:0] duty_active
);

    // A single-cycle prescaler still gets a 1-bit counter that stays at 0.
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PW-1:0]    pre_cnt_q, pre_cnt_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] duty_q, duty_d;
    logic             pstart_q, pstart_d;
    logic             pwm_q, pwm_d;
    logic             tick;
    logic             wrap;

    assign tick = en && (pre_cnt_q == PW'(PRESCALE - 1));
    assign wrap = tick && (cnt_q == WIDTH'(PERIOD - 1));

    always_comb begin
        pre_cnt_d = pre_cnt_q;
        cnt_d     = cnt_q;
        duty_d    = duty_q;
        pstart_d  = 1'b0;
        // Compare uses the current count and duty; result shows one clk later.
        // cnt never reaches PERIOD, so duty >= PERIOD gives a full-on period.
        pwm_d     = en && (cnt_q < duty_q);

        if (!en) begin
            // Disabled: counters parked at 0 and duty tracks the producer, so
            // the first enabled cycle starts a fresh period with current duty.
            pre_cnt_d = '0;
            cnt_d     = '0;
            duty_d    = duty_in;
        end else if (tick) begin
            pre_cnt_d = '0;
            if (wrap) begin
                cnt_d    = '0;
                duty_d   = duty_in;
                pstart_d = 1'b1;
            end else begin
                cnt_d = cnt_q + WIDTH'(1);
            end
        end else begin
            pre_cnt_d = pre_cnt_q + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_cnt_q <= '0;
            cnt_q     <= '0;
            duty_q    <= '0;
            pstart_q  <= 1'b0;
            pwm_q     <= 1'b0;
        end else begin
            pre_cnt_q <= pre_cnt_d;
            cnt_q     <= cnt_d;
            duty_q    <= duty_d;
            pstart_q  <= pstart_d;
            pwm_q     <= pwm_d;
        end
    end

    assign pwm_out      = pwm_q ^ ACTIVE_LOW;
    assign period_start = pstart_q;
    assign duty_active  = duty_q;

endmodule

// File: tb/tb_pwm_led_driver.sv
module tb_pwm_led_driver;

    typedef struct {
        logic       pwm;
        logic       ps;
        logic [9:0] duty;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   total = 0;
    int   bad   = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // u0: defaults (PERIOD=1023, PRESCALE=1, ACTIVE_LOW=1)
    logic r0, e0, p0, ps0;
    logic [9:0] d0, da0;
    // u1: PERIOD=8, PRESCALE=3, ACTIVE_LOW=0
    logic r1, e1, p1, ps1;
    logic [9:0] d1, da1;
    // u2: PERIOD=8, PRESCALE=1, ACTIVE_LOW=0
    logic r2, e2, p2, ps2;
    logic [9:0] d2, da2;

    pwm_led_driver u0 (
        .clk(clk), .rst(r0), .en(e0), .duty_in(d0),
        .pwm_out(p0), .period_start(ps0), .duty_active(da0)
    );

    pwm_led_driver #(.WIDTH(10), .PERIOD(8), .PRESCALE(3), .ACTIVE_LOW(1'b0)) u1 (
        .clk(clk), .rst(r1), .en(e1), .duty_in(d1),
        .pwm_out(p1), .period_start(ps1), .duty_active(da1)
    );

    pwm_led_driver #(.WIDTH(10), .PERIOD(8), .PRESCALE(1), .ACTIVE_LOW(1'b0)) u2 (
        .clk(clk), .rst(r2), .en(e2), .duty_in(d2),
        .pwm_out(p2), .period_start(ps2), .duty_active(da2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reset u2, then park it disabled so duty_active picks up dv.
    task automatic prep_u2(input logic [9:0] dv);
        r2 = 1'b1; e2 = 1'b0; d2 = dv;
        step();
        r2 = 1'b0;
        step();
        step();
    endtask

    task automatic test_reset();
        r0 = 1'b1; e0 = 1'b0; d0 = 10'd256;
        r1 = 1'b1; e1 = 1'b0; d1 = 10'd5;
        r2 = 1'b1; e2 = 1'b0; d2 = 10'd3;
        step();
        step();
        total++; if (p0 !== 1'b1) begin bad++; $display("FAIL reset u0 pwm_out got=%b want=1", p0); end
        total++; if (ps0 !== 1'b0) begin bad++; $display("FAIL reset u0 period_start got=%b want=0", ps0); end
        total++; if (da0 !== 10'd0) begin bad++; $display("FAIL reset u0 duty_active got=%0d want=0", da0); end
        total++; if (p1 !== 1'b0) begin bad++; $display("FAIL reset u1 pwm_out got=%b want=0", p1); end
        total++; if (da1 !== 10'd0) begin bad++; $display("FAIL reset u1 duty_active got=%0d want=0", da1); end
        total++; if (p2 !== 1'b0) begin bad++; $display("FAIL reset u2 pwm_out got=%b want=0", p2); end
    endtask

    // Released straight into en=1 with duty_in=256: first period runs duty 0.
    task automatic test_default_period();
        r0 = 1'b0; e0 = 1'b1;
        for (int n = 1; n <= 3200; n++) begin
            e.pwm  = !(n >= 1024 && ((n - 1024) % 1023) < 256);
            e.ps   = (n % 1023) == 0;
            e.duty = (n >= 1023) ? 10'd256 : 10'd0;
            sb.push_back(e);
            step();
            e = sb.pop_front();
            total++; if (p0 !== e.pwm) begin bad++; $display("FAIL default n=%0d pwm_out got=%b want=%b", n, p0, e.pwm); end
            total++; if (ps0 !== e.ps) begin bad++; $display("FAIL default n=%0d period_start got=%b want=%b", n, ps0, e.ps); end
            total++; if (da0 !== e.duty) begin bad++; $display("FAIL default n=%0d duty_active got=%0d want=%0d", n, da0, e.duty); end
        end
    endtask

    task automatic test_duty_extremes();
        logic [9:0] vals [2];
        vals[0] = 10'd0;
        vals[1] = 10'd1023;
        for (int v = 0; v < 2; v++) begin
            r0 = 1'b1; e0 = 1'b0; d0 = vals[v];
            step();
            r0 = 1'b0;
            step();
            step();
            total++; if (da0 !== vals[v]) begin bad++; $display("FAIL extremes track duty_active got=%0d want=%0d", da0, vals[v]); end
            e0 = 1'b1;
            for (int n = 1; n <= 3 * 1023 + 5; n++) begin
                e.pwm  = (vals[v] == 10'd0);
                e.ps   = (n % 1023) == 0;
                e.duty = vals[v];
                sb.push_back(e);
                step();
                e = sb.pop_front();
                total++; if (p0 !== e.pwm) begin bad++; $display("FAIL extremes duty=%0d n=%0d pwm_out got=%b want=%b", vals[v], n, p0, e.pwm); end
                total++; if (ps0 !== e.ps) begin bad++; $display("FAIL extremes duty=%0d n=%0d period_start got=%b want=%b", vals[v], n, ps0, e.ps); end
            end
            e0 = 1'b0;
        end
    endtask

    // PRESCALE=3, PERIOD=8, duty 5: high 15 clks, low 9, period 24.
    task automatic test_prescale();
        r1 = 1'b1; e1 = 1'b0; d1 = 10'd5;
        step();
        r1 = 1'b0;
        step();
        step();
        e1 = 1'b1;
        for (int n = 1; n <= 72; n++) begin
            e.pwm  = ((n - 1) % 24) < 15;
            e.ps   = (n % 24) == 0;
            e.duty = 10'd5;
            sb.push_back(e);
            step();
            e = sb.pop_front();
            total++; if (p1 !== e.pwm) begin bad++; $display("FAIL prescale n=%0d pwm_out got=%b want=%b", n, p1, e.pwm); end
            total++; if (ps1 !== e.ps) begin bad++; $display("FAIL prescale n=%0d period_start got=%b want=%b", n, ps1, e.ps); end
            total++; if (da1 !== e.duty) begin bad++; $display("FAIL prescale n=%0d duty_active got=%0d want=%0d", n, da1, e.duty); end
        end
    endtask

    // duty_in 3 -> 6 at cnt=4: current period keeps 3, next uses 6.
    task automatic test_duty_change();
        int de;
        prep_u2(10'd3);
        e2 = 1'b1;
        for (int n = 1; n <= 24; n++) begin
            de     = (n <= 8) ? 3 : 6;
            e.pwm  = ((n - 1) % 8) < de;
            e.ps   = (n % 8) == 0;
            e.duty = (n < 8) ? 10'd3 : 10'd6;
            sb.push_back(e);
            step();
            e = sb.pop_front();
            total++; if (p2 !== e.pwm) begin bad++; $display("FAIL duty_change n=%0d pwm_out got=%b want=%b", n, p2, e.pwm); end
            total++; if (ps2 !== e.ps) begin bad++; $display("FAIL duty_change n=%0d period_start got=%b want=%b", n, ps2, e.ps); end
            total++; if (da2 !== e.duty) begin bad++; $display("FAIL duty_change n=%0d duty_active got=%0d want=%0d", n, da2, e.duty); end
            if (n == 4) d2 = 10'd6;
        end
    endtask

    // en drops mid-period, duty tracks while low, re-enable starts at cnt=0.
    task automatic test_enable_drop();
        int k;
        prep_u2(10'd4);
        e2 = 1'b1;
        for (int n = 1; n <= 32; n++) begin
            if (n <= 10) begin
                e.pwm = ((n - 1) % 8) < 4;
                e.ps  = (n % 8) == 0;
            end else if (n <= 15) begin
                e.pwm = 1'b0;
                e.ps  = 1'b0;
            end else begin
                k     = n - 16;
                e.pwm = (k % 8) < 4;
                e.ps  = (k % 8) == 7;
            end
            e.duty = (n == 13) ? 10'd2 : 10'd4;
            sb.push_back(e);
            step();
            e = sb.pop_front();
            total++; if (p2 !== e.pwm) begin bad++; $display("FAIL enable_drop n=%0d pwm_out got=%b want=%b", n, p2, e.pwm); end
            total++; if (ps2 !== e.ps) begin bad++; $display("FAIL enable_drop n=%0d period_start got=%b want=%b", n, ps2, e.ps); end
            total++; if (da2 !== e.duty) begin bad++; $display("FAIL enable_drop n=%0d duty_active got=%0d want=%0d", n, da2, e.duty); end
            if (n == 10) e2 = 1'b0;
            if (n == 12) d2 = 10'd2;
            if (n == 13) d2 = 10'd4;
            if (n == 15) e2 = 1'b1;
        end
    endtask

    // rst while on at cnt=2: output off next clk, period restarts with duty 0.
    task automatic test_reset_mid_period();
        int k;
        prep_u2(10'd6);
        e2 = 1'b1;
        for (int n = 1; n <= 24; n++) begin
            if (n <= 2) begin
                e.pwm  = 1'b1;
                e.ps   = 1'b0;
                e.duty = 10'd6;
            end else if (n == 3) begin
                e.pwm  = 1'b0;
                e.ps   = 1'b0;
                e.duty = 10'd0;
            end else begin
                k      = n - 4;
                e.pwm  = (k >= 8) && ((k % 8) < 6);
                e.ps   = (k % 8) == 7;
                e.duty = (k >= 7) ? 10'd6 : 10'd0;
            end
            sb.push_back(e);
            step();
            e = sb.pop_front();
            total++; if (p2 !== e.pwm) begin bad++; $display("FAIL reset_mid n=%0d pwm_out got=%b want=%b", n, p2, e.pwm); end
            total++; if (ps2 !== e.ps) begin bad++; $display("FAIL reset_mid n=%0d period_start got=%b want=%b", n, ps2, e.ps); end
            total++; if (da2 !== e.duty) begin bad++; $display("FAIL reset_mid n=%0d duty_active got=%0d want=%0d", n, da2, e.duty); end
            if (n == 2) r2 = 1'b1;
            if (n == 3) r2 = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_default_period();
        test_duty_extremes();
        test_prescale();
        test_duty_change();
        test_enable_drop();
        test_reset_mid_period();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
